// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared communication-path types and constants
package comm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    EMIT
  } state_t;

  // Group size shared with the write-side address generator.
  localparam int REPEAT_DEF = 6;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int PAD_W      = 8;
  localparam logic [PAD_W-1:0] SAMPLE_PAD = 8'h00;

endpackage

// File: rtl/repeat_counter.sv
// rtl/repeat_counter.sv - per-address beat counter, terminal at REPEAT-1
module repeat_counter
  import comm_pkg::*;
#(
  parameter int REPEAT = REPEAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign terminal = (r_count == 8'(REPEAT - 1));

endmodule

// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - fetches a frame of words and emits each REPEAT times
module frame_reader
  import comm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int REPEAT = REPEAT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [15:0]             length,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd_en,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [DATA_W+PAD_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  state_t                    r_state;
  logic [ADDR_W-1:0]         r_addr;
  logic [15:0]               r_remain;
  logic                      r_mem_rd_en;
  logic [DATA_W+PAD_W-1:0]   r_out_data;
  logic                      r_out_valid;
  logic                      r_busy;
  logic                      r_done;

  logic w_accept;
  logic w_last_beat;
  logic w_cnt_clear;
  logic w_cnt_enable;

  assign w_accept     = (r_state == EMIT) && r_out_valid && out_ready;
  assign w_cnt_clear  = (r_state == WAIT);
  assign w_cnt_enable = w_accept && !w_last_beat;

  repeat_counter #(
    .REPEAT (REPEAT)
  ) u_repeat_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_cnt_clear),
    .enable   (w_cnt_enable),
    .terminal (w_last_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remain    <= '0;
      r_mem_rd_en <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (length != 16'd0) begin
              r_addr      <= base_addr;
              r_remain    <= length;
              r_mem_rd_en <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= FETCH;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        FETCH: begin
          r_mem_rd_en <= 1'b0;
          r_state     <= WAIT;
        end
        WAIT: begin
          // Memory has a fixed one-cycle latency, so rdata is valid here.
          r_out_data  <= {mem_rdata, SAMPLE_PAD};
          r_out_valid <= 1'b1;
          r_state     <= EMIT;
        end
        EMIT: begin
          if (w_accept && w_last_beat) begin
            r_out_valid <= 1'b0;
            if (r_remain > 16'd1) begin
              r_addr      <= r_addr + ADDR_W'(1);
              r_remain    <= r_remain - 16'd1;
              r_mem_rd_en <= 1'b1;
              r_state     <= FETCH;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_rd_en = r_mem_rd_en;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/frame_reader.md
# frame_reader

Read-side counterpart of the write-path address generator in the communication system. Given a base address and word count, it fetches 16-bit words from a synchronous memory, left-justifies each into a signed 24-bit sample (`{word, 8'h00}`), and presents every word `REPEAT` times on a valid/ready output stream, matching the write side's per-address strobe grouping. It sits between the sample memory and the downstream transmit datapath.

## Interface
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 16: memory word width. Output width is `DATA_W+8`.
- `REPEAT`, default 6: output beats per fetched word. Legal range 1..255.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a frame read. Sampled only in IDLE.
- `base_addr` in ADDR_W: first word address. Latched on an accepted `start`.
- `length` in 16: number of words to read. Latched on an accepted `start`.
- `mem_addr` out ADDR_W: memory read address.
- `mem_rd_en` out 1: memory read strobe, one cycle per word.
- `mem_rdata` in DATA_W: memory data. Valid the cycle after `mem_rd_en`; fixed 1-cycle latency.
- `out_data` out DATA_W+8: signed sample, `{mem_rdata, 8'h00}`.
- `out_valid` out 1: sample valid.
- `out_ready` in 1: downstream accept.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: single-cycle pulse at frame end.

## Operation
- **Reset:** all outputs are 0 and the FSM is in IDLE. Internal address, word count and beat count clear to 0.
- **States:**
  - **IDLE:** `start`=1 with `length`≠0 latches `base_addr`/`length` and goes to FETCH. `start`=1 with `length`=0 pulses `done` in the next cycle and stays in IDLE, with no memory access.
  - **FETCH:** `mem_rd_en`=1, `mem_addr`=current address. Next state is WAIT.
  - **WAIT:** capture `{mem_rdata, 8'h00}` into `out_data` on the exiting edge. Beat count clears. Next state is EMIT.
  - **EMIT:** `out_valid`=1. A beat completes on each edge with `out_valid && out_ready`.
    - Beat count < `REPEAT`-1: increment it and stay in EMIT.
    - Otherwise, words remaining > 1: address +1 (wraps modulo 2^ADDR_W, 16'hFFFF → 16'h0000), remaining −1, go to FETCH.
    - Otherwise: go to IDLE and pulse `done`.
- **Handshake:** while `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` hold stable. `out_valid` never drops without an accepted beat.
- **Busy behaviour:** `start` is ignored while `busy`=1. `base_addr` and `length` are don't-care outside the IDLE accept edge.
- **Reset mid-frame:** everything returns immediately to reset values. No `done` pulse is generated and the frame is abandoned.
- **Defaults:** `mem_addr` holds its last value when `mem_rd_en`=0. `out_data` holds its last sample while `out_valid`=0.

## Timing
- **Start:** `start` accepted at edge 0, giving cycle 0 = FETCH (`mem_rd_en`=1), cycle 1 = WAIT, cycle 2 = EMIT (first `out_valid`). Start-to-first-sample latency is 2 cycles.
- **Inter-word gap:** if the last beat of word k is accepted at edge n, `mem_rd_en` is high in cycle n and word k+1 is valid from cycle n+2. This gives 2 bubble cycles per word.
- **Throughput:** with `out_ready` held at 1, a frame of L words takes L·(REPEAT+2) cycles from the start edge to the final accept.
- **Frame end:** the final accept at edge n gives `done`=1 and `busy`=0 in cycle n, with `done` low again in cycle n+1. A `start` presented in cycle n is accepted at edge n+1.
- **Zero-length frame:** `done`=1 in the cycle after the accepting edge. `busy` stays 0 throughout.

## Structure
- **Shared package `comm_pkg`:**
  - FSM state enum: IDLE, FETCH, WAIT, EMIT.
  - Default `REPEAT`=6, shared with the write side's group size.
  - Widths `ADDR_W`/`DATA_W` and the 8-bit sample pad constant.
- **Sub-module `repeat_counter`:**
  - Inputs: clear, enable. Output: terminal flag at `REPEAT`-1.
  - The same counting rule the write side applies per address, so both ends share it.
- **Top level:** FSM, address/length registers and the output register.

## Test plan
- **Basic frame.** Setup: mem[0x0010]=0x1234, mem[0x0011]=0xABCD, `REPEAT`=6, `out_ready`=1; start with base=0x0010, len=2.
  - Exactly 6×0x123400 then 6×0xABCD00.
  - `mem_addr` sequence 0x0010, 0x0011.
  - First `out_valid` 2 cycles after the start edge.
  - `done` pulses once, 16 cycles after the start edge.
- **Backpressure.** Same frame, `out_ready` toggling 1,0,0,1,…
  - `out_data` is stable during stalls.
  - Still exactly 12 beats, no duplicates and no drops.
  - `mem_rd_en` fires exactly twice.
- **Wrap-around.** base=0xFFFF, len=2.
  - `mem_addr` is 0xFFFF, then 0x0000.
  - Data matches mem[0xFFFF] then mem[0x0000].
- **Zero length and busy rejection.**
  - len=0: `done` pulses next cycle, with no `mem_rd_en` and no `out_valid`.
  - A second `start` mid-frame is ignored, and only one `done` occurs.
- **Reset mid-frame.** Assert `rst_n`=0 during EMIT of word 1 of 3.
  - All outputs go to 0 asynchronously and no `done` pulses.
  - A new start after release runs cleanly from the new base.
- **Back-to-back frames.** Hold `start` high in the `done` cycle.
  - The second frame's FETCH begins one cycle after `done`.
